clk_div_monitor: RTL and testbench

Measures a divided clock derived from `clk_i`, such as the output of the divide-by-N blocks. Samples the monitored signal on both edges of `clk_i`. Reports its period and high time in `clk_i` half-cycles. Flags lock once the measured ratio matches the expected divide ratio. Sits beside each clock divider as a built-in self-check for bring-up and for the divider regression bench.

---
 rtl/clk_div_monitor.sv | 185 ++++++++++++++++++
 tb/tb_clk_div_monitor.sv | 396 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_monitor.sv
// rtl/clk_div_monitor.sv - divided-clock period/high-time monitor with ratio lock (option macro: CLK_DIV_MONITOR_DUTY_CHECK_EN)
module clk_div_monitor #(
    parameter int WIDTH      = 6,
    parameter int N          = 3,
    parameter int LOCK_COUNT = 4
) (
    input  logic             clk_i,
    input  logic             rst,
    input  logic             mon_i,
    output logic [WIDTH-1:0] period_o,
    output logic [WIDTH-1:0] high_o,
    output logic             valid_o,
    output logic             lock_o,
    output logic             err_o
);

    localparam int               LW         = $clog2(LOCK_COUNT + 1);
    localparam logic [WIDTH-1:0] CNT_MAX    = '1;
    localparam logic [WIDTH-1:0] ONE        = WIDTH'(1);
    localparam logic [WIDTH-1:0] EXP_PERIOD = WIDTH'(2 * N);
    localparam logic [LW-1:0]    LOCK_MAX   = LW'(LOCK_COUNT);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        MEASURE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;

    logic             p_s;
    logic             n_s;
    logic             last;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] cnt_next;
    logic [WIDTH-1:0] high_q;
    logic [WIDTH-1:0] high_q_next;
    logic [LW-1:0]    lock_cnt;
    logic [LW-1:0]    lock_cnt_next;

    logic             rise1;
    logic             fall1;
    logic             rise2;
    logic             fall2;
    logic             any_rise;
    logic [WIDTH-1:0] c1;
    logic [WIDTH-1:0] period_meas;
    logic [WIDTH-1:0] high_meas;
    logic             match;
    logic             timeout;

    logic [WIDTH-1:0] period_next;
    logic [WIDTH-1:0] high_out_next;
    logic             valid_next;
    logic             err_next;

    function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] c);
        return (c == CNT_MAX) ? c : c + ONE;
    endfunction

    // Negedge half of the double-edge sampler
    always_ff @(negedge clk_i or posedge rst) begin
        if (rst) begin
            n_s <= 1'b0;
        end else begin
            n_s <= mon_i;
        end
    end

    // Posedge sample, stream history, half-cycle counter and captured high time
    always_ff @(posedge clk_i or posedge rst) begin
        if (rst) begin
            p_s    <= 1'b0;
            last   <= 1'b0;
            cnt    <= '0;
            high_q <= '0;
        end else begin
            p_s    <= mon_i;
            last   <= n_s;
            cnt    <= cnt_next;
            high_q <= high_q_next;
        end
    end

    // Walk the pair (p_s then n_s) one sample at a time, after the previous pair's n_s
    always_comb begin
        rise1       = ~last & p_s;
        fall1       = last & ~p_s;
        rise2       = ~p_s & n_s;
        fall2       = p_s & ~n_s;
        any_rise    = rise1 | rise2;
        c1          = rise1 ? ONE : sat_inc(cnt);
        cnt_next    = rise2 ? ONE : sat_inc(c1);
        // Period ends just before whichever sample rose
        period_meas = rise1 ? cnt : c1;
        // A fall ahead of the rise in the same pair closes the period being reported;
        // a fall after the rise belongs to the next period
        high_meas   = (fall1 & rise2) ? cnt : high_q;
        if (fall2) begin
            high_q_next = c1;
        end else if (fall1) begin
            high_q_next = cnt;
        end else begin
            high_q_next = high_q;
        end
        timeout = ~any_rise & (cnt_next == CNT_MAX);
    end

`ifdef CLK_DIV_MONITOR_DUTY_CHECK_EN
    localparam logic [WIDTH-1:0] EXP_HIGH = WIDTH'(N);
    assign match = (period_meas == EXP_PERIOD) && (high_meas == EXP_HIGH);
`else
    assign match = (period_meas == EXP_PERIOD);
`endif

    // FSM state register
    always_ff @(posedge clk_i or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state, lock counting and next output values
    always_comb begin
        state_next    = state;
        valid_next    = 1'b0;
        err_next      = 1'b0;
        lock_cnt_next = lock_cnt;
        period_next   = period_o;
        high_out_next = high_o;
        case (state)
            IDLE: begin
                if (any_rise) begin
                    state_next = ARMED;
                end
            end
            ARMED, MEASURE: begin
                if (timeout) begin
                    state_next    = IDLE;
                    err_next      = 1'b1;
                    lock_cnt_next = '0;
                end else if (any_rise) begin
                    state_next    = MEASURE;
                    valid_next    = 1'b1;
                    period_next   = period_meas;
                    high_out_next = high_meas;
                    if (match) begin
                        if (lock_cnt != LOCK_MAX) begin
                            lock_cnt_next = lock_cnt + LW'(1);
                        end
                    end else begin
                        lock_cnt_next = '0;
                        err_next      = 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Registered outputs and lock counter
    always_ff @(posedge clk_i or posedge rst) begin
        if (rst) begin
            lock_cnt <= '0;
            period_o <= '0;
            high_o   <= '0;
            valid_o  <= 1'b0;
            lock_o   <= 1'b0;
            err_o    <= 1'b0;
        end else begin
            lock_cnt <= lock_cnt_next;
            period_o <= period_next;
            high_o   <= high_out_next;
            valid_o  <= valid_next;
            lock_o   <= (lock_cnt_next == LOCK_MAX);
            err_o    <= err_next;
        end
    end

endmodule

// File: tb/tb_clk_div_monitor.sv
// tb/tb_clk_div_monitor.sv - self-checking bench for clk_div_monitor against a sample-stream reference model
module tb_clk_div_monitor;

    localparam int W   = 6;
    localparam int N   = 3;
    localparam int LC  = 4;
    localparam int SAT = 63;
`ifdef CLK_DIV_MONITOR_DUTY_CHECK_EN
    localparam bit DUTY = 1'b1;
`else
    localparam bit DUTY = 1'b0;
`endif

    logic         clk_i = 1'b0;
    logic         rst   = 1'b1;
    logic         mon_i = 1'b0;
    logic [W-1:0] period_o;
    logic [W-1:0] high_o;
    logic         valid_o;
    logic         lock_o;
    logic         err_o;

    int checks = 0;
    int errors = 0;

    clk_div_monitor #(.WIDTH(W), .N(N), .LOCK_COUNT(LC)) dut (
        .clk_i   (clk_i),
        .rst     (rst),
        .mon_i   (mon_i),
        .period_o(period_o),
        .high_o  (high_o),
        .valid_o (valid_o),
        .lock_o  (lock_o),
        .err_o   (err_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference model: absolute sample indices, rise/fall positions, lengths by subtraction
    bit           pend_p, pend_n, m_prev, m_s, m_rose, m_report;
    int           m_idx, m_last_rise, m_rises, m_high, m_lockc, m_per, m_hrep;
    bit           exp_valid, exp_err, exp_lock;
    logic [W-1:0] exp_period, exp_high;

    function automatic int sat(input int v);
        return (v > SAT) ? SAT : v;
    endfunction

    always @(negedge clk_i) begin
        if (!rst) pend_n = mon_i;
    end

    always @(posedge clk_i or posedge rst) begin
        if (rst) begin
            m_prev = 1'b0; m_idx = 0; m_last_rise = 0; m_rises = 0; m_high = 0; m_lockc = 0;
            pend_p = 1'b0; pend_n = 1'b0;
            exp_valid = 1'b0; exp_err = 1'b0; exp_lock = 1'b0; exp_period = '0; exp_high = '0;
        end else begin
            m_rose = 1'b0;
            m_report = 1'b0;
            exp_valid = 1'b0;
            exp_err = 1'b0;
            for (int k = 0; k < 2; k++) begin
                m_s = (k == 0) ? pend_p : pend_n;
                m_idx++;
                if (m_prev && !m_s) m_high = sat(m_idx - m_last_rise);
                if (!m_prev && m_s) begin
                    m_rose = 1'b1;
                    if (m_rises > 0) begin
                        m_report = 1'b1;
                        m_per = sat(m_idx - m_last_rise);
                        m_hrep = m_high;
                    end
                    m_last_rise = m_idx;
                    m_rises++;
                end
                m_prev = m_s;
            end
            if (m_report) begin
                exp_valid = 1'b1;
                exp_period = W'(m_per);
                exp_high = W'(m_hrep);
                if (m_per == 2 * N && (!DUTY || m_hrep == N)) begin
                    m_lockc = (m_lockc < LC) ? m_lockc + 1 : LC;
                end else begin
                    m_lockc = 0;
                    exp_err = 1'b1;
                end
            end else if (!m_rose && m_rises > 0 && (m_idx - m_last_rise + 1) >= SAT) begin
                exp_err = 1'b1;
                m_lockc = 0;
                m_rises = 0;
            end
            exp_lock = (m_lockc == LC);
            pend_p = mon_i;
        end
    end

    task automatic drive_half(input logic v);
        @(clk_i);
        #1 mon_i = v;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        mon_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        checks++;
        if ({valid_o, err_o, lock_o, period_o, high_o} !== 15'd0) begin
            errors++;
            $display("FAIL reset_state: got %h expected 0", {valid_o, err_o, lock_o, period_o, high_o});
        end
        @(negedge clk_i);
        #2 rst = 1'b0;
    endtask

    task automatic test_div3();
        int nv = 0, nerr = 0, cyc = 0, last_v = -1;
        for (int i = 0; i < 48; i++) begin
            drive_half((i % 6) < 3);
            if (clk_i) begin
                cyc++;
                checks++;
                if ({valid_o, err_o, lock_o, period_o, high_o} !== {exp_valid, exp_err, exp_lock, exp_period, exp_high}) begin
                    errors++;
                    $display("FAIL div3_model t=%0t got %h expected %h", $time, {valid_o, err_o, lock_o, period_o, high_o}, {exp_valid, exp_err, exp_lock, exp_period, exp_high});
                end
                if (err_o) nerr++;
                if (valid_o) begin
                    nv++;
                    if (nv == 1) begin
                        checks++;
                        if (period_o !== W'(2 * N) || high_o !== W'(N)) begin
                            errors++;
                            $display("FAIL div3_first: got p=%0d h=%0d expected p=%0d h=%0d", period_o, high_o, 2 * N, N);
                        end
                    end
                    if (nv == LC - 1 || nv == LC) begin
                        checks++;
                        if (lock_o !== (nv == LC)) begin
                            errors++;
                            $display("FAIL div3_lock_at_%0d: got %b expected %b", nv, lock_o, (nv == LC));
                        end
                    end
                    if (last_v >= 0) begin
                        checks++;
                        if (cyc - last_v != N) begin
                            errors++;
                            $display("FAIL div3_spacing: got %0d expected %0d", cyc - last_v, N);
                        end
                    end
                    last_v = cyc;
                end
            end
        end
        checks++;
        if (nerr != 0 || nv < LC) begin
            errors++;
            $display("FAIL div3_summary: got err=%0d valid=%0d expected err=0 valid>=%0d", nerr, nv, LC);
        end
    endtask

    task automatic test_div2();
        int nv = 0, nerr = 0;
        bit lock_bad = 1'b0;
        for (int i = 0; i < 32; i++) begin
            drive_half((i % 4) < 2);
            if (clk_i) begin
                checks++;
                if ({valid_o, err_o, lock_o, period_o, high_o} !== {exp_valid, exp_err, exp_lock, exp_period, exp_high}) begin
                    errors++;
                    $display("FAIL div2_model t=%0t got %h expected %h", $time, {valid_o, err_o, lock_o, period_o, high_o}, {exp_valid, exp_err, exp_lock, exp_period, exp_high});
                end
                if (valid_o) nv++;
                if (nv >= 2 && valid_o && err_o) nerr++;
                if (nv >= 2 && lock_o) lock_bad = 1'b1;
            end
        end
        checks++;
        if (nv < 3 || nerr != nv - 1 || lock_bad || period_o !== W'(4)) begin
            errors++;
            $display("FAIL div2_summary: got valid=%0d err=%0d lock_seen=%b p=%0d expected err=valid-1 lock_seen=0 p=4", nv, nerr, lock_bad, period_o);
        end
    endtask

    task automatic test_duty();
        int nerr = 0;
        for (int i = 0; i < 42; i++) begin
            drive_half((i % 6) < 3);
            if (clk_i) begin
                checks++;
                if ({valid_o, err_o, lock_o, period_o, high_o} !== {exp_valid, exp_err, exp_lock, exp_period, exp_high}) begin
                    errors++;
                    $display("FAIL duty_pre_model t=%0t got %h expected %h", $time, {valid_o, err_o, lock_o, period_o, high_o}, {exp_valid, exp_err, exp_lock, exp_period, exp_high});
                end
            end
        end
        checks++;
        if (lock_o !== 1'b1) begin
            errors++;
            $display("FAIL duty_prelock: got %b expected 1", lock_o);
        end
        for (int i = 0; i < 24; i++) begin
            drive_half((i % 6) < 4);
            if (clk_i) begin
                checks++;
                if ({valid_o, err_o, lock_o, period_o, high_o} !== {exp_valid, exp_err, exp_lock, exp_period, exp_high}) begin
                    errors++;
                    $display("FAIL duty_model t=%0t got %h expected %h", $time, {valid_o, err_o, lock_o, period_o, high_o}, {exp_valid, exp_err, exp_lock, exp_period, exp_high});
                end
                if (err_o) nerr++;
            end
        end
        checks++;
        if (DUTY ? (nerr == 0 || lock_o !== 1'b0) : (nerr != 0 || lock_o !== 1'b1 || high_o !== W'(4))) begin
            errors++;
            $display("FAIL duty_summary: got err=%0d lock=%b h=%0d expected duty_check=%b behaviour", nerr, lock_o, high_o, DUTY);
        end
    endtask

    task automatic test_timeout();
        int nerr = 0, nv = 0;
        for (int i = 0; i < 42; i++) begin
            drive_half((i % 6) < 3);
            if (clk_i) begin
                checks++;
                if ({valid_o, err_o, lock_o, period_o, high_o} !== {exp_valid, exp_err, exp_lock, exp_period, exp_high}) begin
                    errors++;
                    $display("FAIL timeout_pre_model t=%0t got %h expected %h", $time, {valid_o, err_o, lock_o, period_o, high_o}, {exp_valid, exp_err, exp_lock, exp_period, exp_high});
                end
            end
        end
        checks++;
        if (lock_o !== 1'b1) begin
            errors++;
            $display("FAIL timeout_prelock: got %b expected 1", lock_o);
        end
        for (int i = 0; i < 80; i++) begin
            drive_half(1'b0);
            if (clk_i) begin
                checks++;
                if ({valid_o, err_o, lock_o, period_o, high_o} !== {exp_valid, exp_err, exp_lock, exp_period, exp_high}) begin
                    errors++;
                    $display("FAIL timeout_model t=%0t got %h expected %h", $time, {valid_o, err_o, lock_o, period_o, high_o}, {exp_valid, exp_err, exp_lock, exp_period, exp_high});
                end
                if (err_o) nerr++;
                if (valid_o) nv++;
            end
        end
        checks++;
        if (nerr != 1 || nv != 0 || lock_o !== 1'b0) begin
            errors++;
            $display("FAIL timeout_summary: got err=%0d valid=%0d lock=%b expected err=1 valid=0 lock=0", nerr, nv, lock_o);
        end
        for (int i = 0; i < 48; i++) begin
            drive_half((i % 6) < 3);
            if (clk_i) begin
                checks++;
                if ({valid_o, err_o, lock_o, period_o, high_o} !== {exp_valid, exp_err, exp_lock, exp_period, exp_high}) begin
                    errors++;
                    $display("FAIL relock_model t=%0t got %h expected %h", $time, {valid_o, err_o, lock_o, period_o, high_o}, {exp_valid, exp_err, exp_lock, exp_period, exp_high});
                end
            end
        end
        checks++;
        if (lock_o !== 1'b1) begin
            errors++;
            $display("FAIL relock: got %b expected 1", lock_o);
        end
    endtask

    task automatic test_pulse();
        int nv = 0;
        bit seen = 1'b0;
        for (int i = 0; i < 5; i++) drive_half(1'b0);
        if (!clk_i) drive_half(1'b0);
        drive_half(1'b1);
        for (int i = 0; i < 30; i++) begin
            drive_half((i < 5) ? 1'b0 : (((i - 5) % 6) < 3));
            if (clk_i) begin
                checks++;
                if ({valid_o, err_o, lock_o, period_o, high_o} !== {exp_valid, exp_err, exp_lock, exp_period, exp_high}) begin
                    errors++;
                    $display("FAIL pulse_model t=%0t got %h expected %h", $time, {valid_o, err_o, lock_o, period_o, high_o}, {exp_valid, exp_err, exp_lock, exp_period, exp_high});
                end
                if (valid_o) begin
                    nv++;
                    if (nv == 2) begin
                        seen = 1'b1;
                        checks++;
                        if (high_o !== W'(1)) begin
                            errors++;
                            $display("FAIL pulse_high: got %0d expected 1", high_o);
                        end
                    end
                end
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL pulse_valid: got %0d valids expected >=2", nv);
        end
    endtask

    task automatic test_async_reset();
        int cyc = 0, first_v = -1;
        for (int i = 0; i < 42; i++) begin
            drive_half((i % 6) < 3);
            if (clk_i) begin
                checks++;
                if ({valid_o, err_o, lock_o, period_o, high_o} !== {exp_valid, exp_err, exp_lock, exp_period, exp_high}) begin
                    errors++;
                    $display("FAIL rst_pre_model t=%0t got %h expected %h", $time, {valid_o, err_o, lock_o, period_o, high_o}, {exp_valid, exp_err, exp_lock, exp_period, exp_high});
                end
            end
        end
        checks++;
        if (lock_o !== 1'b1) begin
            errors++;
            $display("FAIL rst_prelock: got %b expected 1", lock_o);
        end
        drive_half(1'b1);
        drive_half(1'b1);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({valid_o, err_o, lock_o, period_o, high_o} !== 15'd0) begin
            errors++;
            $display("FAIL rst_async: got %h expected 0", {valid_o, err_o, lock_o, period_o, high_o});
        end
        mon_i = 1'b0;
        @(posedge clk_i);
        @(negedge clk_i);
        #2 rst = 1'b0;
        for (int i = 0; i < 48; i++) begin
            drive_half((i % 6) < 3);
            if (clk_i) begin
                cyc++;
                checks++;
                if ({valid_o, err_o, lock_o, period_o, high_o} !== {exp_valid, exp_err, exp_lock, exp_period, exp_high}) begin
                    errors++;
                    $display("FAIL rst_post_model t=%0t got %h expected %h", $time, {valid_o, err_o, lock_o, period_o, high_o}, {exp_valid, exp_err, exp_lock, exp_period, exp_high});
                end
                if (valid_o && first_v < 0) first_v = cyc;
            end
        end
        checks++;
        if (first_v < N) begin
            errors++;
            $display("FAIL rst_two_rises: got first valid at cycle %0d expected >= %0d", first_v, N);
        end
    endtask

    task automatic test_random();
        int hi, lo, reps, nv = 0;
        for (int seg = 0; seg < 40; seg++) begin
            hi = $urandom_range(1, 6);
            lo = ($urandom_range(0, 9) == 0) ? $urandom_range(58, 70) : $urandom_range(1, 6);
            reps = $urandom_range(1, 4);
            for (int r = 0; r < reps; r++) begin
                for (int h = 0; h < hi + lo; h++) begin
                    drive_half(h < hi);
                    if (clk_i) begin
                        checks++;
                        if ({valid_o, err_o, lock_o, period_o, high_o} !== {exp_valid, exp_err, exp_lock, exp_period, exp_high}) begin
                            errors++;
                            $display("FAIL random_model t=%0t hi=%0d lo=%0d got %h expected %h", $time, hi, lo, {valid_o, err_o, lock_o, period_o, high_o}, {exp_valid, exp_err, exp_lock, exp_period, exp_high});
                        end
                        if (valid_o) nv++;
                    end
                end
            end
        end
        checks++;
        if (nv == 0) begin
            errors++;
            $display("FAIL random_activity: got 0 valids expected >0");
        end
    endtask

    initial begin
        test_reset();
        test_div3();
        test_div2();
        test_duty();
        test_timeout();
        test_pulse();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
